or_share_sched: RTL and testbench

Time-shared OR-reduction scheduler: up to four requesters each present a WIDTH-bit operand and get back the OR of all its bits. A single 1-bit two-input OR stage is shared among them, so operands are reduced serially, one bit per clock. A round-robin arbiter picks the next requester, and a small FSM sequences load, reduce and done. The block sits in front of the OR datapath; the multi-gate OR tree is replaced by one gate reused over time.

---
 rtl/or_share_sched.sv | 124 ++++++++++++
 tb/tb_or_share_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/or_share_sched.sv
// or_share_sched: time-shared OR-reduction of up to four requesters' operands through one 1-bit OR stage
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      request per requester (bit i = requester i)
//   data     operands, data[i*WIDTH +: WIDTH] belongs to requester i
//   gnt      one-hot grant to the requester being served, else 0
//   busy     high while an operation is in LOAD, REDUCE or DONE
//   done     one-cycle pulse marking result/done_id valid
//   result   OR of all bits of the granted operand
//   done_id  index of the requester result belongs to
module or_share_sched #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data,
    output logic [3:0]         gnt,
    output logic               busy,
    output logic               done,
    output logic               result,
    output logic [1:0]         done_id
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, LOAD, REDUCE, DONE} state_t;
    state_t state_q, state_d;
    logic [1:0] ptr_q, ptr_d, w_q, w_d, win;
    logic found;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic busy_q, busy_d, done_q, done_d, result_q, result_d;
    logic [1:0] done_id_q, done_id_d;
    // round-robin: first set req bit at or after ptr, 2-bit index wraps 3->0
    always_comb begin
        win = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && req[ptr_q + 2'(k)]) begin
                win = ptr_q + 2'(k);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        w_d = w_q;
        sh_d = sh_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        gnt_d = gnt_q;
        done_d = done_q;
        result_d = result_q;
        done_id_d = done_id_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    w_d = win;
                    gnt_d = 4'b0001 << win;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sh_d = data[int'(w_q)*WIDTH +: WIDTH];
                acc_d = 1'b0;
                cnt_d = '0;
                state_d = REDUCE;
            end
            REDUCE: begin
                acc_d = acc_q | sh_q[0];
                sh_d = sh_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = acc_q | sh_q[0];
                    done_id_d = w_q;
                    done_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d = w_q + 2'd1;
                gnt_d = 4'b0000;
                done_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= 2'd0;
            w_q <= 2'd0;
            sh_q <= '0;
            acc_q <= 1'b0;
            cnt_q <= '0;
            gnt_q <= 4'b0000;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            result_q <= 1'b0;
            done_id_q <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            w_q <= w_d;
            sh_q <= sh_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            gnt_q <= gnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            result_q <= result_d;
            done_id_q <= done_id_d;
        end
    end
    assign gnt = gnt_q;
    assign busy = busy_q;
    assign done = done_q;
    assign result = result_q;
    assign done_id = done_id_q;
endmodule

// File: tb/tb_or_share_sched.sv
// tb_or_share_sched: directed vector bench for or_share_sched at WIDTH=4 and WIDTH=1
module tb_or_share_sched;
    logic clk, rst_n;
    logic [3:0] req, gnt;
    logic [15:0] data;
    logic busy, done, result;
    logic [1:0] done_id;
    logic [3:0] r1, g1;
    logic [1:0] d1;
    logic b1, dn1, res1;
    logic [1:0] id1;
    int total = 0;
    int pass = 0;
    or_share_sched #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data), .gnt(gnt),
        .busy(busy), .done(done), .result(result), .done_id(done_id)
    );
    or_share_sched #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(r1), .data(d1), .gnt(g1),
        .busy(b1), .done(dn1), .result(res1), .done_id(id1)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        logic [1:0]  id;
        logic        res;
    } vec_t;
    vec_t vecs[9];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
    // one full operation; called #1 after an edge, returns #1 after the edge that re-enters IDLE
    task automatic op(input logic [3:0] r, input logic [15:0] d, input logic [1:0] id,
                      input logic res, input string tag);
        int n;
        req = r;
        data = d;
        @(posedge clk);
        #1;
        chk({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << id));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, 5);
        chk({tag, "_res"}, 32'(result), 32'(res));
        chk({tag, "_id"}, 32'(done_id), 32'(id));
        chk({tag, "_gnt_done"}, 32'(gnt), 32'(4'b0001 << id));
        req = 4'b0000;
        @(posedge clk);
        #1;
        chk({tag, "_end"}, {29'd0, busy, done, |gnt}, 32'd0);
    endtask
    initial begin
        int cyc, nd, bad_g, bad_r, n;
        int dcyc[5];
        logic [1:0] dids[5];
        int gr[2], dc[2];
        logic [1:0] wid[2];
        logic wres[2];
        logic [3:0] pg;
        vecs[0] = '{4'b0001, 16'hFFF0, 2'd0, 1'b0};
        vecs[1] = '{4'b0100, 16'h0800, 2'd2, 1'b1};
        vecs[2] = '{4'b0100, 16'h0100, 2'd2, 1'b1};
        vecs[3] = '{4'b0100, 16'h0F00, 2'd2, 1'b1};
        vecs[4] = '{4'b0001, 16'h0002, 2'd0, 1'b1};
        vecs[5] = '{4'b0100, 16'hF0FF, 2'd2, 1'b0};
        vecs[6] = '{4'b1010, 16'h8000, 2'd3, 1'b1};
        vecs[7] = '{4'b1010, 16'h0000, 2'd1, 1'b0};
        vecs[8] = '{4'b1111, 16'h0400, 2'd2, 1'b1};
        req = 4'b0000;
        data = 16'h0000;
        r1 = 4'b0000;
        d1 = 2'b00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outs", {26'd0, gnt, busy, done}, 32'd0);
        chk("rst_res", {29'd0, result, done_id}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // table of single operations, starting from a fresh reset
        do_reset();
        for (int i = 0; i < 9; i++)
            op(vecs[i].req, vecs[i].data, vecs[i].id, vecs[i].res, $sformatf("v%0d", i));
        // all four requesting continuously after reset
        do_reset();
        req = 4'b1111;
        data = 16'h2222;
        cyc = 0;
        nd = 0;
        bad_g = 0;
        bad_r = 0;
        for (int i = 0; i < 5; i++) begin
            dcyc[i] = -100;
            dids[i] = 2'bxx;
        end
        while (nd < 5 && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!$onehot0(gnt)) bad_g++;
            if (done) begin
                dcyc[nd] = cyc;
                dids[nd] = done_id;
                if (!result || gnt != (4'b0001 << done_id)) bad_r++;
                nd++;
            end
        end
        req = 4'b0000;
        chk("held_ndone", nd, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("held_id%0d", i), 32'(dids[i]), i % 4);
        for (int i = 1; i < 5; i++) chk($sformatf("held_gap%0d", i), dcyc[i] - dcyc[i-1], 7);
        chk("held_gnt_onehot", bad_g, 0);
        chk("held_res_gnt", bad_r, 0);
        @(posedge clk);
        #1;
        chk("held_idle", 32'(busy), 32'd0);
        // req dropped and data changed after the operand was captured
        req = 4'b0001;
        data = 16'h0004;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        req = 4'b0000;
        data = 16'h0000;
        n = 2;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drop_lat", n, 5);
        chk("drop_res", 32'(result), 32'd1);
        chk("drop_id", 32'(done_id), 32'd0);
        @(posedge clk);
        #1;
        chk("drop_idle", 32'(busy), 32'd0);
        // reset in the middle of REDUCE
        req = 4'b0100;
        data = 16'h0F00;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {26'd0, gnt, busy, done}, 32'd0);
        chk("mid_rst_res", {29'd0, result, done_id}, 32'd0);
        req = 4'b0000;
        bad_r = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done || busy) bad_r++;
        end
        chk("mid_rst_quiet", bad_r, 0);
        rst_n = 1'b1;
        op(4'b0011, 16'h00F0, 2'd0, 1'b0, "post_rst0");
        op(4'b0011, 16'h00F0, 2'd1, 1'b1, "post_rst1");
        // WIDTH=1 instance
        r1 = 4'b0011;
        d1 = 2'b10;
        for (int i = 0; i < 2; i++) begin
            gr[i] = -100;
            dc[i] = -200;
            wid[i] = 2'bxx;
            wres[i] = 1'bx;
        end
        pg = g1;
        cyc = 0;
        nd = 0;
        n = 0;
        while (nd < 2 && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            if (g1 != 4'b0000 && pg == 4'b0000 && n < 2) begin
                gr[n] = cyc;
                n++;
            end
            pg = g1;
            if (dn1) begin
                dc[nd] = cyc;
                wid[nd] = id1;
                wres[nd] = res1;
                nd++;
            end
        end
        r1 = 4'b0000;
        chk("w1_id0", 32'(wid[0]), 32'd0);
        chk("w1_res0", 32'(wres[0]), 32'd0);
        chk("w1_id1", 32'(wid[1]), 32'd1);
        chk("w1_res1", 32'(wres[1]), 32'd1);
        chk("w1_lat", dc[0] - gr[0], 2);
        chk("w1_occ", gr[1] - gr[0], 4);
        chk("w1_done_gap", dc[1] - dc[0], 4);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
